// File: rtl/issue_ctrl_pkg.sv
// Shared RV32I opcode constants and per-opcode register-use decode for the issue stage.
package issue_ctrl_pkg;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_ALUI   = 7'b0010011;
  localparam logic [6:0] OPCODE_ALUR   = 7'b0110011;

  localparam int RS1_USE      = 0;
  localparam int RS2_USE      = 1;
  localparam int RD_USE       = 2;
  localparam int USE_W        = 3;
  localparam int SCOREBOARD_W = 32;

  // Unknown opcodes use no registers so they flow through to decode, which flags them.
  function automatic logic [USE_W-1:0] reg_use(input logic [6:0] opcode);
    logic [USE_W-1:0] u;
    u = '0;
    case (opcode)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL: u[RD_USE] = 1'b1;
      OPCODE_JALR, OPCODE_LOAD, OPCODE_ALUI: begin
        u[RS1_USE] = 1'b1;
        u[RD_USE]  = 1'b1;
      end
      OPCODE_BRANCH, OPCODE_STORE: begin
        u[RS1_USE] = 1'b1;
        u[RS2_USE] = 1'b1;
      end
      OPCODE_ALUR: u = '1;
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction buffer between fetch and issue; flush empties it at the clock edge.
module issue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int W      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [W-1:0]              i_data,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output logic [W-1:0]              o_head,
  output logic                      o_head_valid,
  output logic [$clog2(QDEPTH):0]   o_count
);

  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0]  r_mem [QDEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push       = i_push && !i_flush && (r_count != (AW+1)'(QDEPTH));
  assign w_pop        = i_pop && !i_flush && (r_count != '0);
  assign o_head       = r_mem[r_rptr];
  assign o_head_valid = (r_count != '0);
  assign o_count      = r_count;

  // Storage is cleared on reset so the head reads as zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: buffers fetched instructions and holds back any whose registers await a load.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int XLEN   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_valid,
  output logic                    if_ready,
  input  logic [XLEN-1:0]         if_instr,
  input  logic [XLEN-1:0]         if_pc,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [XLEN-1:0]         id_instr,
  output logic [XLEN-1:0]         id_pc,
  input  logic                    flush,
  input  logic                    ld_done,
  input  logic [4:0]              ld_rd,
  output logic [SCOREBOARD_W-1:0] busy,
  output logic [31:0]             stall_cycles
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [2*XLEN-1:0]       w_head;
  logic                    w_head_valid;
  logic [CW-1:0]           w_count;
  logic                    w_push;
  logic                    w_pop;
  logic [USE_W-1:0]        w_use;
  logic [4:0]              w_rs1;
  logic [4:0]              w_rs2;
  logic [4:0]              w_rd;
  logic                    w_hazard;
  logic                    w_issue_load;
  logic [SCOREBOARD_W-1:0] r_busy;
  logic [31:0]             r_stall;

  issue_fifo #(.QDEPTH(QDEPTH), .W(2*XLEN)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_data       ({if_instr, if_pc}),
    .i_pop        (w_pop),
    .i_flush      (flush),
    .o_head       (w_head),
    .o_head_valid (w_head_valid),
    .o_count      (w_count)
  );

  assign id_instr = w_head[2*XLEN-1:XLEN];
  assign id_pc    = w_head[XLEN-1:0];

  assign w_use = reg_use(id_instr[6:0]);
  assign w_rs1 = id_instr[19:15];
  assign w_rs2 = id_instr[24:20];
  assign w_rd  = id_instr[11:7];

  // WAW is included so a late load cannot overwrite a younger result in rd.
  assign w_hazard = (w_use[RS1_USE] && r_busy[w_rs1]) ||
                    (w_use[RS2_USE] && r_busy[w_rs2]) ||
                    (w_use[RD_USE]  && r_busy[w_rd]);

  assign if_ready     = (w_count < CW'(QDEPTH));
  assign id_valid     = w_head_valid && !w_hazard && !flush;
  assign w_push       = if_valid && if_ready && !flush;
  assign w_pop        = id_valid && id_ready;
  assign w_issue_load = w_pop && (id_instr[6:0] == OPCODE_LOAD) && (w_rd != 5'd0);

  assign busy         = r_busy;
  assign stall_cycles = r_stall;

  // The set is written last so it wins over a same-cycle clear of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (ld_done && (ld_rd != 5'd0)) r_busy[ld_rd] <= 1'b0;
      if (w_issue_load)               r_busy[w_rd]  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_head_valid && w_hazard && !flush && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, flush/back-pressure sequences, and random traffic vs a queue model.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        flush = 1'b0;
  logic        ld_done = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] busy;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  issue_ctrl #(.QDEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .flush        (flush),
    .ld_done      (ld_done),
    .ld_rd        (ld_rd),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00228333;
  localparam logic [31:0] LUI5 = 32'h000002B7;
  localparam logic [31:0] LW0  = 32'h00002003;
  localparam logic [31:0] LW7  = 32'h00002383;
  localparam logic [31:0] ADD8 = 32'h00A48433;
  localparam logic [31:0] ADDI = 32'h00100593;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO as a queue of {instr, pc}, pending-load set as a bit array.
  logic [63:0] mq[$];
  logic [31:0] mbusy  = '0;
  logic [31:0] mstall = '0;

  logic        s_idv, s_ifr;
  logic [31:0] s_busy, s_stall, s_instr, s_pc;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        ldd;
    logic        e_idv;
    logic [31:0] e_busy;
    logic [31:0] e_stall;
  } vec_t;
  vec_t vecs[$];

  // bit0 = reads rs1, bit1 = reads rs2, bit2 = writes rd
  function automatic logic [2:0] ref_use(input logic [31:0] ins);
    case (ins[6:0])
      7'h37, 7'h17, 7'h6f: return 3'b100;
      7'h67, 7'h03, 7'h13: return 3'b101;
      7'h63, 7'h23:        return 3'b011;
      7'h33:               return 3'b111;
      default:             return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mbusy  = '0;
    mstall = '0;
  endtask

  task automatic run_cycle();
    logic [31:0] hi;
    logic [2:0]  u;
    logic        hv, haz, idv, pop, push_ok;
    @(negedge clk);
    hv  = (mq.size() > 0);
    hi  = hv ? mq[0][63:32] : 32'h0;
    u   = ref_use(hi);
    haz = hv && ((u[0] && mbusy[hi[19:15]]) || (u[1] && mbusy[hi[24:20]]) ||
                 (u[2] && mbusy[hi[11:7]]));
    idv = hv && !haz && !flush;
    s_idv = id_valid; s_ifr = if_ready; s_busy = busy; s_stall = stall_cycles;
    s_instr = id_instr; s_pc = id_pc;
    chk("model_id_valid", {31'b0, s_idv}, {31'b0, idv});
    chk("model_if_ready", {31'b0, s_ifr}, {31'b0, (mq.size() < 2)});
    chk("model_busy", s_busy, mbusy);
    chk("model_stall", s_stall, mstall);
    if (hv) begin
      chk("model_id_instr", s_instr, hi);
      chk("model_id_pc", s_pc, mq[0][31:0]);
    end
    @(posedge clk);
    pop     = idv && id_ready;
    push_ok = if_valid && (mq.size() < 2) && !flush;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push_ok) mq.push_back({if_instr, if_pc});
    end
    if (ld_done && ld_rd != 5'd0) mbusy[ld_rd] = 1'b0;
    if (pop && hi[6:0] == 7'h03 && hi[11:7] != 5'd0) mbusy[hi[11:7]] = 1'b1;
    if (haz && !flush && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0; ld_done = 1'b0; ld_rd = '0;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic ldd, input logic [4:0] ldrd);
    if_valid = iv; if_instr = ins; if_pc = pc; id_ready = rdy;
    flush = fl; ld_done = ldd; ld_rd = ldrd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    chk({tag, "_if_ready"}, {31'b0, if_ready}, 32'd1);
    chk({tag, "_busy"}, busy, 32'd0);
    chk({tag, "_stall"}, stall_cycles, 32'd0);
    chk({tag, "_id_instr"}, id_instr, 32'd0);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6f;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h13;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h23;
      8: w[6:0] = 7'h33;
      default: w[6:0] = 7'h7f;
    endcase
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    // Reset state
    idle_inputs();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Load-use, WAW, set/clear collision, x0 and invalid opcode
    vecs.push_back('{1'b1, LW5,   1'b0, 1'b0, 32'h0,  32'd0});
    vecs.push_back('{1'b1, ADD6,  1'b0, 1'b1, 32'h0,  32'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'd0});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'd1});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'd2});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'd3});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'd3});
    vecs.push_back('{1'b1, LW5,   1'b0, 1'b0, 32'h0,  32'd3});
    vecs.push_back('{1'b1, LUI5,  1'b0, 1'b1, 32'h0,  32'd3});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'd3});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'd4});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'd5});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'd6});
    vecs.push_back('{1'b1, LW5,   1'b0, 1'b0, 32'h0,  32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b1, 32'h0,  32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'd6});
    vecs.push_back('{1'b1, LW0,   1'b0, 1'b0, 32'h0,  32'd6});
    vecs.push_back('{1'b1, 32'h0, 1'b0, 1'b1, 32'h0,  32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 32'h0,  32'd6});
    vecs.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'd6});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].ins, 32'h100 + 32'(4 * i), 1'b1, 1'b0, vecs[i].ldd, 5'd5);
      run_cycle();
      chk($sformatf("vec%0d_id_valid", i), {31'b0, s_idv}, {31'b0, vecs[i].e_idv});
      chk($sformatf("vec%0d_if_ready", i), {31'b0, s_ifr}, 32'd1);
      chk($sformatf("vec%0d_busy", i), s_busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_stall", i), s_stall, vecs[i].e_stall);
    end

    // Flush with a full FIFO and a pending load
    drive(1'b1, LW7,  32'h300, 1'b1, 1'b0, 1'b0, 5'd0); run_cycle();
    drive(1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd0); run_cycle();
    drive(1'b1, ADD8, 32'h304, 1'b0, 1'b0, 1'b0, 5'd0); run_cycle();
    drive(1'b1, ADDI, 32'h308, 1'b0, 1'b0, 1'b0, 5'd0); run_cycle();
    drive(1'b1, ADDI, 32'h30C, 1'b1, 1'b1, 1'b0, 5'd0); run_cycle();
    chk("flush_full_if_ready", {31'b0, s_ifr}, 32'd0);
    chk("flush_cycle_id_valid", {31'b0, s_idv}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0); run_cycle();
    chk("post_flush_if_ready", {31'b0, s_ifr}, 32'd1);
    chk("post_flush_id_valid", {31'b0, s_idv}, 32'd0);
    chk("post_flush_busy", s_busy, 32'h80);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7); run_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0); run_cycle();
    chk("busy_cleared", s_busy, 32'h0);

    // Back-pressure, then random drain across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDI + 32'(i << 20), 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 5'd0);
      run_cycle();
    end
    chk("backpressure_if_ready", {31'b0, s_ifr}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 5'd0);
      run_cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0); run_cycle();
    run_cycle();
    chk("drained_empty_id_valid", {31'b0, s_idv}, 32'd0);

    // Random traffic with one asynchronous reset mid-run
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
      run_cycle();
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Issue controller between instruction fetch and the decode/execute stage of the RV32I core.
- Buffers fetched instructions in a small FIFO.
- Tracks destination registers of outstanding loads in a scoreboard.
- Holds back any instruction whose source or destination register is still pending a load.
- Drops buffered instructions on a branch/jump redirect; counts hazard-stall cycles for performance analysis.

Parameters:
QDEPTH, 2, instruction FIFO depth in entries (power of two, >= 2)
XLEN, 32, instruction and PC width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, active low
if_valid  in  1  fetch offers an instruction
if_ready  out  1  FIFO can accept; equals (count < QDEPTH)
if_instr  in  XLEN  fetched instruction word
if_pc  in  XLEN  PC of fetched instruction
id_valid  out  1  head instruction is issuable this cycle
id_ready  in  1  decode/execute accepts
id_instr  out  XLEN  head instruction word
id_pc  out  XLEN  head PC
flush  in  1  redirect from branch/jump resolution
ld_done  in  1  a load result is written back this cycle
ld_rd  in  5  destination register of the completing load
busy  out  32  scoreboard bit vector; bit 0 is always 0
stall_cycles  out  32  count of hazard-stall cycles

Behaviour:
- Reset is asynchronous and active-low (rst_n) on a single clock, clk. While rst_n = 0:
  - FIFO is empty, busy = 0, stall_cycles = 0.
  - id_valid = 0, if_ready = 1.
  - id_instr and id_pc read as 0.
- Push: if_valid & if_ready & !flush writes {if_instr, if_pc} at the tail.
  - Earliest appearance on id_* is the next cycle (1-cycle latency, no bypass).
- Pop: id_valid & id_ready removes the head.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo QDEPTH.
- Source and destination use, derived from opcode = instr[6:0] using the shared opcode constants:
  - LUI, AUIPC, JAL: rd only.
  - JALR, LOAD, ALUI: rs1 and rd.
  - BRANCH, STORE: rs1 and rs2, no rd.
  - ALUR: rs1, rs2 and rd.
  - Any other opcode: no sources and no rd; it still issues, and decode flags it invalid.
  - Fields: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
- Hazard (combinational on the head entry) is true if any of:
  - rs1 is used and busy[rs1];
  - rs2 is used and busy[rs2];
  - rd is written and busy[rd] (WAW: a late load must not overwrite a younger result).
- id_valid = head_valid & !hazard & !flush.
- Scoreboard:
  - A LOAD that issues with rd != 0 sets busy[rd] at the clock edge.
  - ld_done clears busy[ld_rd].
  - If the set and the clear target the same register in the same cycle, the set wins.
  - ld_rd = 0 is ignored; busy[0] is hardwired to 0.
- flush:
  - Empties the FIFO at the edge and suppresses id_valid and any push in that cycle.
  - busy is NOT cleared, because issued loads still complete.
  - ld_done is still honoured during a flush.
- stall_cycles increments each cycle with head_valid & hazard & !flush. It saturates at 0xFFFFFFFF.
- if_ready depends only on registered count, so there is no combinational path from id_ready to if_ready.
- Mid-operation reset discards the FIFO and the scoreboard immediately; no handshake completes in that cycle.

Decomposition:
- Shared defines file: existing OPCODE_* constants, plus new localparams for RS1_USE / RS2_USE / RD_USE flag positions and SCOREBOARD_W = 32.
- Sub-module issue_fifo: synchronous FIFO with parameters QDEPTH and width 2*XLEN, a flush input, and count output.
- Hazard logic and scoreboard stay in issue_ctrl.

Test Plan:
- Load-use stall:
  - Stimulus: push lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333); id_ready = 1.
  - Required: lw issues and busy[5] = 1. add is held with id_valid = 0 and stall_cycles increments every cycle. ld_done = 1 with ld_rd = 5 → add issues the next cycle and stall_cycles stops.
- WAW stall:
  - Stimulus: load to x5 pending, then push lui x5,0 (0x000002B7).
  - Required: lui is held until ld_done with ld_rd = 5.
- Set/clear collision:
  - Stimulus: busy[5] = 1; second lw x5 issues in the same cycle as ld_done with ld_rd = 5.
  - Required: busy[5] stays 1.
- Flush:
  - Stimulus: FIFO full (2 entries) with if_valid = 1; assert flush for one cycle.
  - Required: next cycle count = 0, id_valid = 0, the pushed word is discarded, and busy is unchanged.
- x0 and invalid opcode:
  - Stimulus: lw x0 issues; push an all-zero instruction word.
  - Required: busy stays 0. The invalid word issues with no stall.
- Back-pressure and wrap:
  - Stimulus: id_ready = 0 with 3 pushes offered; then drain with random id_ready.
  - Required: if_ready = 0 after 2 entries. All instructions emerge in order with the correct PCs across pointer wrap.
